pic_int_sequencer: RTL
======================

# pic_int_sequencer

Interrupt sequencing controller for the 8259-style PIC. It sits between the IRR block and the CPU bus interface. It resolves the highest-priority masked request, raises INT and runs the two-pulse INTA handshake. It also sets and clears the In-Service Register and drives the interrupt vector onto the data bus during the second acknowledge.

## Interface
- NUM_IR, 8, number of interrupt lines; fixed at 8 for vector encoding
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous and active-low
- irr  input  8  masked requests from IRR block; bit 0 highest priority
- inta_n  input  1  CPU acknowledge strobe, active-low, already synchronised to clk
- eoi  input  1  one-cycle non-specific End-Of-Interrupt pulse from command decode
- vector_base  input  5  ICW2 bits T7..T3
- int_req  output  1  INT to CPU
- isr  output  8  In-Service Register
- vector  output  8  {vector_base, ir_id[2:0]}; valid only while data_oe=1
- data_oe  output  1  data-bus drive enable during second acknowledge

## Operation
- Priority is fixed, IR0 highest.
- A request qualifies when its bit is the lowest set bit of irr and has strictly higher priority than the highest set isr bit (fully nested mode).
- inta_n falling edge detect:
  - inta_n registered once (inta_q).
  - fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- States:
  - IDLE: int_req=0. A qualifying request -> REQ.
  - REQ: int_req=1.
    - fall -> ACK1. Latch ir_id from the current winner and set isr[ir_id].
    - If no request qualifies at the fall, this is a spurious interrupt: ir_id=7, spurious flag set, isr unchanged.
    - Request withdrawn before any fall: stay in REQ. int_req stays 1; an 8259 cannot retract INT.
  - ACK1: int_req=0. rise -> WAIT2.
  - WAIT2: fall -> VEC.
  - VEC: data_oe=1, vector={vector_base, ir_id}. rise -> IDLE.
- EOI:
  - Clears the highest-priority set isr bit.
  - EOI with isr==0 is ignored.
  - EOI in the same cycle as the ACK1 isr set: apply the clear first, then the set. The new bit survives.
- A new request can qualify in IDLE only after returning from VEC; there is no pipelining of acknowledges.
- irr changes after ACK1 do not alter the latched ir_id.
- inta_n falls outside REQ/WAIT2 are ignored.

## Timing
- Reset values: int_req=0, isr=8'h00, data_oe=0, vector=8'h00, state IDLE, inta_q=1.
- rst_n low mid-handshake aborts to IDLE on the next edge. isr is cleared.
- Latency from a qualifying irr to int_req=1: 1 cycle (IDLE->REQ registered).
- int_req drops in the cycle after the first fall is sampled.
- data_oe and vector assert in the cycle after the second fall is sampled. They deassert in the cycle after rise.
- eoi takes effect on isr in the cycle after the pulse.

## Configuration
- PIC_AUTO_EOI_EN defined:
  - The isr bit latched for ir_id is cleared automatically on the rise that ends VEC.
  - The eoi input still clears the highest-priority bit.
  - A spurious cycle clears nothing.
- PIC_AUTO_EOI_EN undefined: isr bits clear only via eoi.

## Structure
- Shared package pic_pkg:
  - NUM_IR constant
  - state enum seq_state_t {IDLE, REQ, ACK1, WAIT2, VEC}
  - SPURIOUS_ID = 3'd7
- One sub-module, pic_priority_resolver. It is combinational and computes from irr and isr:
  - winner id
  - qualify flag (winner beats highest isr)
  - highest-isr id for EOI

## Test plan
- irr=8'h08, vector_base=5'h10, two INTA pulses:
  - int_req rises 1 cycle after irr.
  - isr=8'h08 after first fall.
  - vector=8'h83 with data_oe=1 during second pulse.
- irr=8'h22 simultaneously, two INTA pulses:
  - ir_id=1, vector low bits=3'd1, isr=8'h02.
  - After eoi, isr=8'h00 and the cycle repeats for IR5.
- Nesting:
  - isr=8'h04 with irr=8'h10 -> int_req stays 0.
  - irr=8'h01 -> int_req=1; after ACK1, isr=8'h05.
  - One eoi -> isr=8'h04.
- Spurious: irr=8'h40 raises int_req, irr cleared before first fall -> vector low bits=3'd7, isr unchanged.
- Reset and EOI boundaries:
  - rst_n low in WAIT2 -> next cycle int_req=0, data_oe=0, isr=0, state IDLE.
  - eoi with isr=0 -> no change.
- PIC_AUTO_EOI_EN build: single IR3 handshake -> isr returns to 8'h00 one cycle after the second rise, with no eoi pulse.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared constants, state encoding and priority helper for the 8259-style
// interrupt sequencer.
package pic_pkg;

    localparam int         NUM_IR      = 8;
    localparam logic [2:0] SPURIOUS_ID = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        VEC   = 3'd4
    } seq_state_t;

    // Index of the lowest set bit (highest priority); 0 when v is empty.
    function automatic logic [2:0] first_set(input logic [NUM_IR-1:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (v[i]) id = 3'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational fixed-priority resolver: picks the winning request, decides
// whether it may nest over the in-service level, and finds the EOI target.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] i_irr,
    input  logic [NUM_IR-1:0] i_isr,
    output logic [2:0]        o_win_id,
    output logic              o_qualify,
    output logic [2:0]        o_isr_id,
    output logic              o_isr_any
);

    logic w_irr_any;

    assign w_irr_any = |i_irr;
    assign o_isr_any = |i_isr;
    assign o_win_id  = first_set(i_irr);
    assign o_isr_id  = first_set(i_isr);

    // Fully nested: the winner must strictly outrank every bit in service.
    assign o_qualify = w_irr_any && (!o_isr_any || (o_win_id < o_isr_id));

endmodule

// File: rtl/pic_int_sequencer.sv
// INT / two-pulse INTA sequencer with ISR maintenance and vector drive.
// Optional build macro PIC_AUTO_EOI_EN clears the serviced ISR bit when VEC ends.
module pic_int_sequencer
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] irr,
    input  logic              inta_n,
    input  logic              eoi,
    input  logic [4:0]        vector_base,
    output logic              int_req,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vector,
    output logic              data_oe,
    output seq_state_t        dbg_state
);

    // Handshake: int_req holds in REQ until the first inta_n fall (no retract);
    // the second fall opens VEC, where data_oe qualifies vector until inta_n rises.
    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              r_inta_q;
    logic [NUM_IR-1:0] r_isr;
    logic [2:0]        r_ir_id;
    logic              w_fall;
    logic              w_rise;
    logic              w_ack_latch;
    logic [2:0]        w_win_id;
    logic              w_qualify;
    logic [2:0]        w_isr_id;
    logic              w_isr_any;
    logic [NUM_IR-1:0] w_eoi_clr;
    logic [NUM_IR-1:0] w_auto_clr;
    logic [NUM_IR-1:0] w_set;
    logic [NUM_IR-1:0] w_isr_next;

    pic_priority_resolver u_resolver (
        .i_irr     (irr),
        .i_isr     (r_isr),
        .o_win_id  (w_win_id),
        .o_qualify (w_qualify),
        .o_isr_id  (w_isr_id),
        .o_isr_any (w_isr_any)
    );

    assign w_fall      = r_inta_q & ~inta_n;
    assign w_rise      = ~r_inta_q & inta_n;
    assign w_ack_latch = (r_state == REQ) && w_fall;

    assign w_eoi_clr = (eoi && w_isr_any) ? (8'h01 << w_isr_id) : 8'h00;
    assign w_set     = (w_ack_latch && w_qualify) ? (8'h01 << w_win_id) : 8'h00;

`ifdef PIC_AUTO_EOI_EN
    logic r_spurious;
    logic w_vec_done;

    assign w_vec_done = (r_state == VEC) && w_rise;
    assign w_auto_clr = (w_vec_done && !r_spurious) ? (8'h01 << r_ir_id) : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spurious <= 1'b0;
        end else if (w_ack_latch) begin
            r_spurious <= !w_qualify;
        end
    end
`else
    assign w_auto_clr = 8'h00;
`endif

    // Clears are applied before the acknowledge set, so a same-cycle set survives.
    assign w_isr_next = (r_isr & ~(w_eoi_clr | w_auto_clr)) | w_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_inta_q <= 1'b1;
            r_isr    <= 8'h00;
            r_ir_id  <= 3'd0;
        end else begin
            r_state  <= w_next_state;
            r_inta_q <= inta_n;
            r_isr    <= w_isr_next;
            if (w_ack_latch) begin
                r_ir_id <= w_qualify ? w_win_id : SPURIOUS_ID;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        int_req      = 1'b0;
        data_oe      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_qualify) w_next_state = REQ;
            end
            REQ: begin
                int_req = 1'b1;
                if (w_fall) w_next_state = ACK1;
            end
            ACK1: begin
                if (w_rise) w_next_state = WAIT2;
            end
            WAIT2: begin
                if (w_fall) w_next_state = VEC;
            end
            VEC: begin
                data_oe = 1'b1;
                if (w_rise) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign vector    = data_oe ? {vector_base, r_ir_id} : 8'h00;
    assign isr       = r_isr;
    assign dbg_state = r_state;

endmodule
